// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mc_pkg
// Brief   : Shared constants for the multi-cycle MIPS control unit: ALUOp
//           codes (must match alu), opcode/funct values, FSM state encodings,
//           PC and ALU operand-B select codes, instruction class record.
// Revision: 1.0 - initial release
// ============================================================================
package mc_pkg;

  // ALU operation codes driven on ALUOp; alu decodes the same values
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SRL = 3'd4;
  localparam logic [2:0] ALU_SRA = 3'd5;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;

  // FSM state encodings; 11..15 are illegal and fall back to S_FETCH
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXEC_R  = 4'd2;
  localparam logic [3:0] S_EXEC_I  = 4'd3;
  localparam logic [3:0] S_ALU_WB  = 4'd4;
  localparam logic [3:0] S_MEM_ADR = 4'd5;
  localparam logic [3:0] S_MEM_RD  = 4'd6;
  localparam logic [3:0] S_MEM_WB  = 4'd7;
  localparam logic [3:0] S_MEM_WR  = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;

  // PCSrc select codes
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // ALUSrcB select codes
  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_BRANCH = 2'd3;

  // One-hot instruction class; all zero means unsupported (executed as nop)
  typedef struct packed {
    logic rtype;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic j;
  } iclass_t;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module  : mc_decode
// Brief   : Combinational instruction classifier. Maps opcode/funct to a
//           one-hot instruction class plus the ALUOp and operand-swap flag
//           used by the R-type execute state.
// Revision: 1.0 - initial release
// ============================================================================
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_t    cls_o,
  output logic [2:0] r_aluop_o,
  output logic       r_swap_o
);

  // Classify the instruction; unknown op/funct leaves the class all-zero
  always_comb begin
    cls_o     = '0;
    r_aluop_o = ALU_ADD;
    r_swap_o  = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: begin cls_o.rtype = 1'b1; r_aluop_o = ALU_ADD; end
          FN_SUBU: begin cls_o.rtype = 1'b1; r_aluop_o = ALU_SUB; end
          FN_AND:  begin cls_o.rtype = 1'b1; r_aluop_o = ALU_AND; end
          FN_OR:   begin cls_o.rtype = 1'b1; r_aluop_o = ALU_OR;  end
          // variable shifts take the shift amount from rs, so rt goes to A
          FN_SRLV: begin cls_o.rtype = 1'b1; r_aluop_o = ALU_SRL; r_swap_o = 1'b1; end
          FN_SRAV: begin cls_o.rtype = 1'b1; r_aluop_o = ALU_SRA; r_swap_o = 1'b1; end
          default: ;
        endcase
      end
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_J:    cls_o.j   = 1'b1;
      default: ;
    endcase
  end

endmodule : mc_decode
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mc_ctrl
// Brief   : Multi-cycle MIPS control unit. Moore FSM stepping through
//           fetch/decode/execute/memory/writeback and driving datapath
//           selects, write enables and the ALUOp consumed by alu.
// Revision: 1.0 - initial release
// ============================================================================
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               zero,
  output logic [2:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ALUSwap,
  output logic               ExtOp,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               MemWrite,
  output logic               done,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_q;
  logic [3:0]         state_d;
  logic [3:0]         w_st;
  logic [3:0]         w_ost;
  iclass_t            w_cls;
  logic [2:0]         w_r_aluop;
  logic               w_r_swap;
  logic               w_unsup;
  logic               w_unused_instr;

  // Register fields and immediates are datapath concerns, not control
  assign w_unused_instr = ^instr[25:6];

  mc_decode u_decode (
    .op_i      (instr[31:26]),
    .funct_i   (instr[5:0]),
    .cls_o     (w_cls),
    .r_aluop_o (w_r_aluop),
    .r_swap_o  (w_r_swap)
  );

  assign w_unsup = ~|w_cls;
  assign w_st    = 4'(state_q);
  assign state   = state_q;

  // Next-state selection; illegal encodings recover to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (w_st)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (w_cls.rtype)              state_d = S_EXEC_R;
        else if (w_cls.ori)           state_d = S_EXEC_I;
        else if (w_cls.lw | w_cls.sw) state_d = S_MEM_ADR;
        else if (w_cls.beq)           state_d = S_BRANCH;
        else if (w_cls.j)             state_d = S_JUMP;
        else                          state_d = S_FETCH;
      end
      S_EXEC_R:  state_d = S_ALU_WB;
      S_EXEC_I:  state_d = S_ALU_WB;
      S_MEM_ADR: state_d = w_cls.lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = S_MEM_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= STATE_W'(S_FETCH);
    else       state_q <= STATE_W'(state_d);
  end

  // While reset is held, outputs present FETCH values with enables masked
  assign w_ost = reset ? S_FETCH : w_st;

  // Moore output decode from state (and instr for R-type details)
  always_comb begin
    ALUOp    = ALU_ADD;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REG;
    ALUSwap  = 1'b0;
    ExtOp    = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = PC_ALU;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    MemWrite = 1'b0;
    done     = 1'b0;
    case (w_ost)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
      end
      S_DECODE: begin
        // precompute the branch target into ALUOut
        ALUSrcB = SRCB_BRANCH;
        ExtOp   = 1'b1;
        done    = w_unsup;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = w_r_aluop;
        ALUSwap = w_r_swap;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_OR;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = w_cls.rtype;
        done     = 1'b1;
      end
      S_MEM_ADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ExtOp   = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        done     = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        done     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_SUB;
        PCSrc   = PC_ALUOUT;
        PCWrite = zero;
        done    = 1'b1;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = PC_JUMP;
        done    = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      done     = 1'b0;
    end
  end

endmodule : mc_ctrl
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mc_ctrl
// Brief   : Self-checking bench for mc_ctrl: directed vector table, reset
//           sequences and randomized instructions against a per-cycle
//           reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aop;
    logic       sa;
    logic [1:0] sb;
    logic       swp;
    logic       ext;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       mw;
    logic       dn;
  } out_t;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          cpi;
    int          idx;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic [2:0]  ALUOp;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        ALUSwap;
  logic        ExtOp;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic        IRWrite;
  logic        RegWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic        MemWrite;
  logic        done;
  logic [3:0]  state;

  int checks = 0;
  int errors = 0;
  out_t expq[$];
  vec_t tbl[16];

  mc_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUSwap(ALUSwap),
    .ExtOp(ExtOp), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .done(done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t o(input logic [3:0] st, input logic [2:0] aop,
                             input logic sa, input logic [1:0] sb,
                             input logic swp, input logic ext, input logic pcw,
                             input logic [1:0] pcs, input logic irw,
                             input logic rw, input logic rd, input logic m2r,
                             input logic mw, input logic dn);
    out_t r;
    r.st = st; r.aop = aop; r.sa = sa; r.sb = sb; r.swp = swp; r.ext = ext;
    r.pcw = pcw; r.pcs = pcs; r.irw = irw; r.rw = rw; r.rd = rd;
    r.m2r = m2r; r.mw = mw; r.dn = dn;
    return r;
  endfunction

  function automatic out_t sample();
    return o(state, ALUOp, ALUSrcA, ALUSrcB, ALUSwap, ExtOp, PCWrite, PCSrc,
             IRWrite, RegWrite, RegDst, MemtoReg, MemWrite, done);
  endfunction

  task automatic chk(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: the cycle-by-cycle control word of one instruction
  function automatic void build(input logic [31:0] ins, input logic z);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    logic       r_ok;
    logic [2:0] aop;
    expq.delete();
    r_ok = (op == 6'h00) && (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 ||
                             fn == 6'h25 || fn == 6'h06 || fn == 6'h07);
    expq.push_back(o(S_FETCH, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    if (r_ok) begin
      aop = (fn == 6'h21) ? 3'd0 : (fn == 6'h23) ? 3'd1 : (fn == 6'h24) ? 3'd2 :
            (fn == 6'h25) ? 3'd3 : (fn == 6'h06) ? 3'd4 : 3'd5;
      expq.push_back(o(S_DECODE, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      expq.push_back(o(S_EXEC_R, aop, 1, 0, (fn == 6'h06 || fn == 6'h07), 0, 0, 0, 0, 0, 0, 0, 0, 0));
      expq.push_back(o(S_ALU_WB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
    end else if (op == 6'h0D) begin
      expq.push_back(o(S_DECODE, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      expq.push_back(o(S_EXEC_I, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      expq.push_back(o(S_ALU_WB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    end else if (op == 6'h23 || op == 6'h2B) begin
      expq.push_back(o(S_DECODE, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      expq.push_back(o(S_MEM_ADR, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      if (op == 6'h23) begin
        expq.push_back(o(S_MEM_RD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        expq.push_back(o(S_MEM_WB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
      end else begin
        expq.push_back(o(S_MEM_WR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      end
    end else if (op == 6'h04) begin
      expq.push_back(o(S_DECODE, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      expq.push_back(o(S_BRANCH, 1, 1, 0, 0, 0, z, 1, 0, 0, 0, 0, 0, 1));
    end else if (op == 6'h02) begin
      expq.push_back(o(S_DECODE, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      expq.push_back(o(S_JUMP, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1));
    end else begin
      expq.push_back(o(S_DECODE, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    end
  endfunction

  // Call during a FETCH cycle before its rising edge; returns at a falling edge
  // inside the following FETCH cycle.
  task automatic run_instr(input logic [31:0] ins, input logic z, input int idx,
                           output out_t got_idx, output int ncyc);
    out_t cur;
    bit   fin = 0;
    got_idx = '0;
    ncyc    = 0;
    build(ins, z);
    instr = ins;
    zero  = z;
    #1;
    for (int k = 0; k < 12 && !fin; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      cur = sample();
      if (k == idx) got_idx = cur;
      if (k < expq.size()) chk($sformatf("model_cyc%0d_ins%h", k, ins), cur, expq[k]);
      else chk($sformatf("extra_cyc%0d_ins%h", k, ins), cur, expq[expq.size()-1]);
      if (cur.dn === 1'b1) begin
        fin  = 1;
        ncyc = k + 1;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout_done ins=%h got=no_done exp=done_within_12", ins);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  op;
    logic [5:0]  fns[6];
    logic [31:0] r;
    fns[0] = 6'h21; fns[1] = 6'h23; fns[2] = 6'h24;
    fns[3] = 6'h25; fns[4] = 6'h06; fns[5] = 6'h07;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r = {6'h00, r[25:6], fns[$urandom_range(0, 5)]};
      1: r = {6'h0D, r[25:0]};
      2: r = {6'h23, r[25:0]};
      3: r = {6'h2B, r[25:0]};
      4: r = {6'h04, r[25:0]};
      5: r = {6'h02, r[25:0]};
      6: begin
        do op = 6'($urandom);
        while (op == 6'h00 || op == 6'h0D || op == 6'h23 || op == 6'h2B ||
               op == 6'h04 || op == 6'h02);
        r = {op, r[25:0]};
      end
      default: begin
        do op = 6'($urandom);
        while (op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25 ||
               op == 6'h06 || op == 6'h07);
        r = {6'h00, r[25:6], op};
      end
    endcase
    return r;
  endfunction

  initial begin
    out_t got;
    int   n;
    bit   rw_seen;

    tbl[0]  = '{32'h00221823, 1'b0, 4, 2, o(S_EXEC_R, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{32'h00221823, 1'b0, 4, 3, o(S_ALU_WB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1)};
    tbl[2]  = '{32'h00221823, 1'b0, 4, 1, o(S_DECODE, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{32'h00221807, 1'b0, 4, 2, o(S_EXEC_R, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{32'h00221806, 1'b0, 4, 2, o(S_EXEC_R, 4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{32'h00221821, 1'b0, 4, 2, o(S_EXEC_R, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{32'h00221824, 1'b0, 4, 2, o(S_EXEC_R, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{32'h00221825, 1'b0, 4, 2, o(S_EXEC_R, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{32'h3422FFFF, 1'b0, 4, 2, o(S_EXEC_I, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{32'h3422FFFF, 1'b0, 4, 3, o(S_ALU_WB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1)};
    tbl[10] = '{32'h8C220008, 1'b0, 5, 4, o(S_MEM_WB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1)};
    tbl[11] = '{32'hAC220008, 1'b0, 4, 3, o(S_MEM_WR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)};
    tbl[12] = '{32'h10220003, 1'b1, 3, 2, o(S_BRANCH, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1)};
    tbl[13] = '{32'h10220003, 1'b0, 3, 2, o(S_BRANCH, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1)};
    tbl[14] = '{32'h08000004, 1'b0, 3, 2, o(S_JUMP, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1)};
    tbl[15] = '{32'hFC000000, 1'b0, 2, 1, o(S_DECODE, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1)};

    // Reset held for two edges: FETCH state, FETCH selects, no enables
    reset = 1'b1;
    instr = 32'h0;
    zero  = 1'b0;
    @(negedge clk); #1;
    chk("reset_cyc1", sample(), o(S_FETCH, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); #1;
    chk("reset_cyc2", sample(), o(S_FETCH, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_reset_fetch", sample(), o(S_FETCH, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      run_instr(tbl[i].ins, tbl[i].z, tbl[i].idx, got, n);
      chk($sformatf("vec%0d_ins%h", i, tbl[i].ins), got, tbl[i].exp);
      chk_int($sformatf("vec%0d_cpi", i), n, tbl[i].cpi);
    end

    // Reset during MEM_RD of lw abandons it with no register write
    rw_seen = 0;
    instr = 32'h8C220008;
    zero  = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (RegWrite === 1'b1) rw_seen = 1;
      @(negedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("reset_in_memrd", sample(), o(S_MEM_RD, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("after_abort_fetch", sample(), o(S_FETCH, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    chk_int("abort_regwrite_seen", int'(rw_seen), 0);
    @(negedge clk);
    run_instr(32'h00221823, 1'b0, 3, got, n);
    chk_int("recover_cpi", n, 4);

    // Randomized instructions against the reference model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ri;
      logic        rz;
      int          ecyc;
      ri = rand_instr();
      rz = 1'($urandom);
      build(ri, rz);
      ecyc = expq.size();
      run_instr(ri, rz, 0, got, n);
      chk_int($sformatf("rand%0d_cpi_ins%h", i, ri), n, ecyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the flow above stalls
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_mc_ctrl
`default_nettype wire
